// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_arbiter
// Description : Round-robin arbiter that shares a single external adder
//               between N_REQ requesters.
//
//               A three-state FSM runs the adder:
//                 IDLE : pick a winner and register its operands.
//                 CALC : capture the adder's sum.
//                 DONE : hold the result until the consumer accepts it.
//
//               The search for a winner starts at the round-robin pointer.
//               The pointer moves to the requester just after the winner
//               only when the consumer accepts that winner's result.
//
// Ports       : clk        - single clock, rising-edge active
//               rst        - synchronous, active-high reset
//               req        - per-requester add request (bit i = requester i)
//               op_a/op_b  - packed operands, slice i*WIDTH +: WIDTH
//               gnt        - one-cycle grant pulse, one-hot or zero
//               add_a/add_b- registered operands driven to the shared adder
//               add_sum    - combinational sum returned by the shared adder
//               res_valid  - result available
//               res_id     - requester that owns res_data
//               res_data   - captured sum
//               res_ready  - consumer accepts the result when high together
//                            with res_valid
//               busy       - high whenever the FSM is not in IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     op_a,
    input  logic [N_REQ*WIDTH-1:0]     op_b,
    output logic [N_REQ-1:0]           gnt,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_sum,
    output logic                       res_valid,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic [WIDTH-1:0]           res_data,
    input  logic                       res_ready,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [IDW-1:0]     ptr_q,       ptr_d;
    logic [IDW-1:0]     winner_q,    winner_d;
    logic [N_REQ-1:0]   gnt_q,       gnt_d;
    logic [WIDTH-1:0]   add_a_q,     add_a_d;
    logic [WIDTH-1:0]   add_b_q,     add_b_d;
    logic               res_valid_q, res_valid_d;
    logic [IDW-1:0]     res_id_q,    res_id_d;
    logic [WIDTH-1:0]   res_data_q,  res_data_d;

    // ------------------------------------------------------------------------
    // Split the packed operand buses into per-requester arrays so the winner's
    // operands can be picked with a plain array index.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_a_arr [N_REQ];
    logic [WIDTH-1:0] w_b_arr [N_REQ];

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_a_arr[g] = op_a[g*WIDTH +: WIDTH];
            assign w_b_arr[g] = op_b[g*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin search.
    //
    // The candidates are checked in the order ptr, ptr+1, ... modulo N_REQ,
    // and the first requester with req set wins. The sum ptr+k is one bit
    // wider than ptr, so it cannot overflow before the single conditional
    // subtract that wraps it back into range. This works for any N_REQ,
    // including values that are not a power of two.
    // ------------------------------------------------------------------------
    logic           w_sel_found;
    logic [IDW-1:0] w_sel_idx;
    logic [IDW:0]   w_cand_sum;
    logic [IDW-1:0] w_cand;

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand_sum  = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (w_cand_sum >= (IDW+1)'(N_REQ)) begin
                w_cand_sum = w_cand_sum - (IDW+1)'(N_REQ);
            end
            w_cand = w_cand_sum[IDW-1:0];
            if (!w_sel_found && req[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    // Pointer value to load when the current winner's result is accepted.
    logic [IDW-1:0] w_ptr_next;

    always_comb begin
        if (winner_q == IDW'(N_REQ-1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = winner_q + IDW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic.
    //
    // gnt defaults to zero, so it is high only in the cycle right after an
    // IDLE selection. Every other register holds its value unless a state
    // explicitly updates it, which keeps add_a/add_b and the result stable
    // while the FSM waits in DONE.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        gnt_d       = '0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (w_sel_found) begin
                    add_a_d            = w_a_arr[w_sel_idx];
                    add_b_d            = w_b_arr[w_sel_idx];
                    gnt_d[w_sel_idx]   = 1'b1;
                    winner_d           = w_sel_idx;
                    state_d            = S_CALC;
                end
            end

            S_CALC: begin
                // add_a/add_b have been stable for a full cycle, so the
                // external adder's combinational sum is settled here.
                res_data_d  = add_sum;
                res_id_d    = winner_q;
                res_valid_d = 1'b1;
                state_d     = S_DONE;
            end

            S_DONE: begin
                // res_valid is always high in DONE, so res_ready alone
                // completes the handshake.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    ptr_d       = w_ptr_next;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. Reset overrides every other input, which also discards
    // a result that is still in CALC or DONE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            gnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            gnt_q       <= gnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt       = gnt_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_rr_arbiter
// Description : Self-checking bench for adder_rr_arbiter.
//
//               The bench models the shared adder itself. A negedge monitor
//               keeps a transaction-level reference model: the rotating
//               pointer, a pending-result scoreboard and the expected
//               protocol phase. Directed scenarios run first, followed by a
//               randomized requester/consumer phase that also includes
//               occasional resets.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*W-1:0]     op_a;
    logic [N*W-1:0]     op_b;
    logic [N-1:0]       gnt;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic [W-1:0]       add_sum;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [W-1:0]       res_data;
    logic               res_ready;
    logic               busy;

    // The shared adder. The sum is truncated to W bits, so there is no
    // carry-out.
    assign add_sum = add_a + add_b;

    adder_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Comparison bookkeeping
    // ------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
    } exp_t;

    exp_t         sb[$];
    int           m_stage     = 0;   // 0 idle, 1 grant cycle, 2 result waiting
    int           m_ptr       = 0;
    bit           m_armed     = 1'b0;
    bit           m_after_rst = 1'b0;
    int           n_done      = 0;
    int           last_id     = 0;
    logic [W-1:0] last_data   = '0;
    int           done_cyc    = 0;

    // The first requester with req set, scanning from p upwards with wrap.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = r >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] bus, input int idx);
        logic [N*W-1:0] t;
        t = bus >> (idx * W);
        return t[W-1:0];
    endfunction

    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] eg;
        if (m_armed) begin
            chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            if (m_after_rst) begin
                chk("rst_res_valid", 64'(res_valid), 64'd0);
                chk("rst_gnt",       64'(gnt),       64'd0);
                chk("rst_busy",      64'(busy),      64'd0);
                chk("rst_res_id",    64'(res_id),    64'd0);
                chk("rst_res_data",  64'(res_data),  64'd0);
                chk("rst_add_a",     64'(add_a),     64'd0);
                chk("rst_add_b",     64'(add_b),     64'd0);
                m_after_rst = 1'b0;
            end
            case (m_stage)
                0: begin
                    chk("idle_busy",      64'(busy),      64'd0);
                    chk("idle_res_valid", 64'(res_valid), 64'd0);
                    chk("idle_gnt",       64'(gnt),       64'd0);
                    if (!rst && req != '0) begin
                        e.id = rr_pick(req, m_ptr);
                        e.a  = slice_of(op_a, e.id);
                        e.b  = slice_of(op_b, e.id);
                        e.s  = e.a + e.b;
                        sb.push_back(e);
                        m_stage = 1;
                    end
                end
                1: begin
                    e  = sb[0];
                    eg = N'(1) << e.id;
                    chk("calc_busy",      64'(busy),      64'd1);
                    chk("calc_gnt",       64'(gnt),       64'(eg));
                    chk("calc_res_valid", 64'(res_valid), 64'd0);
                    chk("calc_add_a",     64'(add_a),     64'(e.a));
                    chk("calc_add_b",     64'(add_b),     64'(e.b));
                    m_stage = 2;
                end
                default: begin
                    e = sb[0];
                    chk("done_busy",      64'(busy),      64'd1);
                    chk("done_gnt",       64'(gnt),       64'd0);
                    chk("done_res_valid", 64'(res_valid), 64'd1);
                    chk("done_res_id",    64'(res_id),    64'(e.id));
                    chk("done_res_data",  64'(res_data),  64'(e.s));
                    chk("done_add_a",     64'(add_a),     64'(e.a));
                    chk("done_add_b",     64'(add_b),     64'(e.b));
                    if (!rst && res_ready) begin
                        last_id   = int'(res_id);
                        last_data = res_data;
                        done_cyc  = cyc;
                        n_done++;
                        m_ptr = (e.id + 1) % N;
                        void'(sb.pop_front());
                        m_stage = 0;
                    end
                end
            endcase
        end
        if (rst) begin
            m_armed     = 1'b1;
            m_after_rst = 1'b1;
            m_stage     = 0;
            m_ptr       = 0;
            sb.delete();
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [N*W-1:0] m;
        m    = {{((N-1)*W){1'b0}}, {W{1'b1}}} << (idx * W);
        op_a = (op_a & ~m) | ((N*W)'(a) << (idx * W));
        op_b = (op_b & ~m) | ((N*W)'(b) << (idx * W));
    endtask

    task automatic set_req(input int idx, input bit v);
        if (v) req = req | (N'(1) << idx);
        else   req = req & ~(N'(1) << idx);
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int idx);
        logic [N-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    task automatic wait_done(input int prev);
        int b = 0;
        while (n_done == prev && b < 60) begin
            tick();
            b++;
        end
        if (n_done == prev) chk("wait_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_gnt(input int idx, input bit drop);
        int b = 0;
        bit seen = 1'b0;
        while (!seen && b < 60) begin
            tick();
            b++;
            if (bit_of(gnt, idx)) begin
                seen = 1'b1;
                if (drop) set_req(idx, 1'b0);
            end
        end
        if (!seen) chk("wait_gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid();
        int b = 0;
        while (!res_valid && b < 60) begin
            tick();
            b++;
        end
        if (!res_valid) chk("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        int prev;
        prev = n_done;
        set_ops(idx, a, b);
        set_req(idx, 1'b1);
        res_ready = 1'b1;
        wait_gnt(idx, 1'b1);
        wait_done(prev);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int pc;
        int prev;
        int b;
        logic [N-1:0] t;

        rst       = 1'b1;
        req       = '0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // A single requester, and wrap-around arithmetic.
        issue(0, 32'd129, 32'd1055);
        chk("t_single_data", 64'(last_data), 64'd1184);
        chk("t_single_id",   64'(last_id),   64'd0);
        issue(2, 32'd50, 32'hFFFF_FFF6);
        chk("t_neg_data", 64'(last_data), 64'd40);
        chk("t_neg_id",   64'(last_id),   64'd2);
        issue(2, 32'hFFFF_FFFF, 32'd1);
        chk("t_wrap_data", 64'(last_data), 64'd0);

        // All four requesters held high: expect the order 0,1,2,3,0 from
        // reset, with results 3 cycles apart.
        for (int i = 0; i < N; i++) set_ops(i, W'(i), W'(10 * i));
        req       = '1;
        res_ready = 1'b1;
        tick();
        do_reset(2);
        pc = 0;
        for (int k = 0; k < 5; k++) begin
            prev = n_done;
            wait_done(prev);
            chk("t_rr_id",   64'(last_id),   64'(k % N));
            chk("t_rr_data", 64'(last_data), 64'(11 * (k % N)));
            if (k > 0) chk("t_rr_spacing", 64'(done_cyc - pc), 64'd3);
            pc = done_cyc;
        end
        req = '0;
        repeat (8) tick();

        // Back-pressure: hold the result for 5 cycles, then accept it.
        res_ready = 1'b0;
        set_ops(1, 32'd7, 32'd8);
        set_req(1, 1'b1);
        wait_gnt(1, 1'b1);
        wait_valid();
        repeat (5) tick();
        chk("t_bp_valid_held", 64'(res_valid), 64'd1);
        chk("t_bp_data_held",  64'(res_data),  64'd15);
        res_ready = 1'b1;
        tick();
        chk("t_bp_idle_after", 64'(busy), 64'd0);

        // Reset while a result waits in DONE, then restart from requester 0.
        res_ready = 1'b0;
        set_ops(3, 32'd100, 32'd200);
        set_req(3, 1'b1);
        wait_gnt(3, 1'b0);
        wait_valid();
        req = 4'b1010;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t_rst_valid", 64'(res_valid), 64'd0);
        chk("t_rst_gnt",   64'(gnt),       64'd0);
        chk("t_rst_data",  64'(res_data),  64'd0);
        chk("t_rst_busy",  64'(busy),      64'd0);
        res_ready = 1'b1;
        b = 0;
        while (gnt == '0 && b < 20) begin
            tick();
            b++;
        end
        chk("t_rst_first_gnt", 64'(gnt), 64'b0010);
        req = '0;
        repeat (8) tick();

        // Randomized requesters, consumer and occasional resets.
        repeat (1500) begin
            tick();
            rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                t = req;
                if (bit_of(gnt, i)) begin
                    set_req(i, 1'b0);
                end else if (!bit_of(t, i) && $urandom_range(0, 3) == 0) begin
                    set_ops(i,
                            ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom),
                            ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom));
                    set_req(i, 1'b1);
                end else if (bit_of(t, i) && $urandom_range(0, 15) == 0) begin
                    set_req(i, 1'b0);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
        end
        rst       = 1'b0;
        req       = '0;
        res_ready = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one adder (2..8).
REQ-002 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  N_REQ  per-requester add request, bit i = requester i.
REQ-006 Port: op_a  input  N_REQ*WIDTH  packed operand A, slice i*WIDTH +: WIDTH = requester i.
REQ-007 Port: op_b  input  N_REQ*WIDTH  packed operand B, same packing as op_a.
REQ-008 Port: gnt  output  N_REQ  one-cycle grant pulse, at most one bit high.
REQ-009 Port: add_a  output  WIDTH  registered operand A driven to the shared adder.
REQ-010 Port: add_b  output  WIDTH  registered operand B driven to the shared adder.
REQ-011 Port: add_sum  input  WIDTH  combinational sum returned by the shared adder.
REQ-012 Port: res_valid  output  1  result available.
REQ-013 Port: res_id  output  $clog2(N_REQ)  index of requester owning res_data.
REQ-014 Port: res_data  output  WIDTH  captured sum.
REQ-015 Port: res_ready  input  1  consumer accepts result when high with res_valid.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM shall have states IDLE, CALC, DONE; only these are reachable.
REQ-018 IDLE: if any req bit high, shall select winner = first set bit scanning ptr, ptr+1, ... mod N_REQ; register add_a/add_b from winner slices, pulse gnt[winner] for the next cycle, record winner, go to CALC; else stay IDLE.
REQ-019 CALC: shall capture add_sum into res_data, set res_id = winner, set res_valid = 1, go to DONE.
REQ-020 DONE: shall hold res_valid, res_id, res_data, add_a, add_b stable until res_valid && res_ready; on that cycle shall clear res_valid, set ptr = (winner+1) mod N_REQ, go to IDLE.
REQ-021 Latency: req sampled in cycle 0 -> gnt high cycle 1 -> res_valid high cycle 2; minimum issue interval with res_ready tied high = 3 cycles.
REQ-022 Requesters shall hold req and operands until gnt observed; a req bit dropping before selection shall not be granted and shall not disturb state.
REQ-023 req changes while busy shall be ignored until the next IDLE cycle.
REQ-024 Arithmetic: res_data = (op_a + op_b) mod 2^WIDTH via add_sum; no carry-out, signed and unsigned operands give identical bit patterns.
REQ-025 ptr shall wrap from N_REQ-1 to 0; a sole active requester shall be served every round.
REQ-026 With all req bits held high, grant order from reset shall be 0,1,...,N_REQ-1,0,...
REQ-027 res_ready high before res_valid shall have no effect; res_ready high in the cycle res_valid first rises shall complete the transaction that cycle.
REQ-028 gnt shall be one-hot or zero every cycle; gnt shall never be high outside the cycle after IDLE selection.

Reset
REQ-029 rst high at a clock edge shall force state IDLE, ptr = 0, gnt = 0, res_valid = 0, res_id = 0, res_data = 0, add_a = 0, add_b = 0, busy = 0.
REQ-030 rst mid-transaction (CALC or DONE) shall discard the pending result with no res_valid pulse; arbitration restarts from requester 0 on the first cycle after rst falls.
REQ-031 rst shall take priority over every other input in the same cycle.

Verification
REQ-032 Single req[0], op_a=129, op_b=1055 -> gnt[0] cycle 1, res_valid cycle 2, res_data=1184, res_id=0.
REQ-033 req[2], op_a=50, op_b=-10 (0xFFFFFFF6) -> res_data=40, res_id=2; op_a=0xFFFFFFFF, op_b=1 -> res_data=0.
REQ-034 All four req held, operands i and 10*i, res_ready=1 -> res_id sequence 0,1,2,3,0 with res_data 0,11,22,33,0, each 3 cycles apart.
REQ-035 res_ready=0 for 5 cycles after res_valid -> res_valid, res_data, res_id stable, no new gnt; res_ready=1 -> IDLE next cycle.
REQ-036 rst asserted during DONE with req[3] pending -> all outputs zero next cycle; after release with req[1], req[3] high -> gnt[1] first.
REQ-037 Assertions across all scenarios: gnt one-hot-or-zero, busy == (state != IDLE), no res_valid without a prior gnt.
